// File: rtl/duty_phase_loader.sv
// Streams one (duty,phase) beat per transducer into a shadow bank and commits the whole frame on UPDATE.
// Optional build macro: DUTY_PHASE_LOADER_CLEAR_ON_SHORT_EN (zero the unwritten tail of a short frame).
module duty_phase_loader #(
    parameter int TRANS_NUM = 249,
    parameter int IDX_W     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        UPDATE,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [15:0] IN_DATA,
    input  logic        IN_LAST,
    output logic [7:0]  DUTY  [0:TRANS_NUM-1],
    output logic [7:0]  PHASE [0:TRANS_NUM-1],
    output logic        COMMITTED,
    output logic        ERR
);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        DROP     = 2'd1,
        WAIT_UPD = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRANS_NUM - 1);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(TRANS_NUM);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_ready;
    logic              r_commitDly;
    logic              r_committed;
    logic              r_err;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_shadowDuty  [0:TRANS_NUM-1];
    logic [7:0]        r_shadowPhase [0:TRANS_NUM-1];

    logic w_accept;
    logic w_lastBeat;
    logic w_fillBeat;
    logic w_short;
    logic w_overflow;
    logic w_commit;

    assign w_accept   = IN_VALID & r_ready;
    assign w_lastBeat = w_accept & IN_LAST;
    assign w_fillBeat = (r_state == FILL) & w_accept;
    // A LAST that does not land on the final index is a length error, including a LAST one past the end.
    assign w_short    = (r_state == FILL) & w_lastBeat & (r_idx != LAST_IDX);
    assign w_overflow = w_fillBeat & ~IN_LAST & (r_idx == FULL_IDX);
    assign w_commit   = (r_state == WAIT_UPD) & UPDATE;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FILL: begin
                if (w_lastBeat)
                    w_nextState = WAIT_UPD;
                else if (w_overflow)
                    w_nextState = DROP;
            end
            DROP: begin
                if (w_lastBeat)
                    w_nextState = WAIT_UPD;
            end
            WAIT_UPD: begin
                if (UPDATE)
                    w_nextState = FILL;
            end
            default: w_nextState = FILL;
        endcase
    end

    // Ready is registered from the next state so it drops on the same edge that enters WAIT_UPD.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= FILL;
            r_ready     <= 1'b0;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_commitDly <= 1'b0;
            r_committed <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_ready     <= (w_nextState != WAIT_UPD);
            r_err       <= r_err | w_short | w_overflow;
            r_commitDly <= w_commit;
            r_committed <= r_commitDly;
            if (w_fillBeat) begin
                if (IN_LAST)
                    r_idx <= '0;
                else if (r_idx != FULL_IDX)
                    r_idx <= r_idx + 1'b1;
            end else if ((r_state == DROP) && w_lastBeat) begin
                r_idx <= '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int j = 0; j < TRANS_NUM; j++) begin
                r_shadowDuty[j]  <= '0;
                r_shadowPhase[j] <= '0;
            end
        end else begin
            if (w_fillBeat && (r_idx < FULL_IDX)) begin
                r_shadowDuty[r_idx]  <= IN_DATA[15:8];
                r_shadowPhase[r_idx] <= IN_DATA[7:0];
            end
`ifdef DUTY_PHASE_LOADER_CLEAR_ON_SHORT_EN
            if (w_short) begin
                for (int j = 0; j < TRANS_NUM; j++) begin
                    if (j > int'(r_idx)) begin
                        r_shadowDuty[j]  <= '0;
                        r_shadowPhase[j] <= '0;
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int j = 0; j < TRANS_NUM; j++) begin
                DUTY[j]  <= '0;
                PHASE[j] <= '0;
            end
        end else if (w_commit) begin
            DUTY  <= r_shadowDuty;
            PHASE <= r_shadowPhase;
        end
    end

    assign IN_READY  = r_ready;
    assign COMMITTED = r_committed;
    assign ERR       = r_err;

endmodule
